sc_life_controller: RTL

Game-level sequencer that owns the player life counter in the Frogger datapath. It turns collision, bonus and start events into the counter's 2-bit up/down command and active-low clear. It enforces a respawn grace period after each hit and declares game-over when lives reach zero. It sits between the collision/score logic and the life counter, and its freeze/game-over flags gate the frog and lane movers.

---
 rtl/sc_frogger_pkg.sv | 26 ++
 rtl/sc_respawn_timer.sv | 42 ++++
 rtl/sc_life_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sc_frogger_pkg.sv
// ---------------------------------------------------------------------------
// sc_frogger_pkg
// Shared constants for the Frogger game datapath: life-controller state
// encodings, the up/down command codes understood by the life counter, and
// the life count loaded at the start of every game.
// ---------------------------------------------------------------------------
package sc_frogger_pkg;

    // Life-controller state encodings (3 bits; encoding 7 is unused)
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] INIT     = 3'd1;
    localparam logic [2:0] PLAY     = 3'd2;
    localparam logic [2:0] HIT      = 3'd3;
    localparam logic [2:0] CHECK    = 3'd4;
    localparam logic [2:0] RESPAWN  = 3'd5;
    localparam logic [2:0] GAMEOVER = 3'd6;

    // Life counter up/down command
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;

    // Lives loaded into the counter by an active clear
    localparam int DEFAULT_LIVES = 3;

endpackage

// File: rtl/sc_respawn_timer.sv
// ---------------------------------------------------------------------------
// sc_respawn_timer
// Loadable down-counter. A load presets the count to RESPAWN_CYCLES-1; while
// enabled it counts down and parks at zero. The zero flag is combinational
// on the count register so the owner can leave its wait state on the same
// edge the last cycle completes. Reusable for level-start delays.
//
// Ports:
//   SC_RESPAWNTIMER_CLOCK_50      in   system clock, rising edge
//   SC_RESPAWNTIMER_RESET_InLow   in   async active-low reset, clears count
//   SC_RESPAWNTIMER_load_InHigh   in   preset count to RESPAWN_CYCLES-1
//   SC_RESPAWNTIMER_enable_InHigh in   decrement while non-zero
//   SC_RESPAWNTIMER_zero_OutHigh  out  count is zero
// ---------------------------------------------------------------------------
module sc_respawn_timer #(
    parameter int RESPAWN_CYCLES = 25000000,
    localparam int TIMER_WIDTH   = $clog2(RESPAWN_CYCLES + 1)
) (
    input  logic SC_RESPAWNTIMER_CLOCK_50,
    input  logic SC_RESPAWNTIMER_RESET_InLow,
    input  logic SC_RESPAWNTIMER_load_InHigh,
    input  logic SC_RESPAWNTIMER_enable_InHigh,
    output logic SC_RESPAWNTIMER_zero_OutHigh
);

    localparam logic [TIMER_WIDTH-1:0] LOAD_VALUE = TIMER_WIDTH'(RESPAWN_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] timerCount;

    always_ff @(posedge SC_RESPAWNTIMER_CLOCK_50 or negedge SC_RESPAWNTIMER_RESET_InLow) begin
        if (!SC_RESPAWNTIMER_RESET_InLow) begin
            timerCount <= '0;
        end else if (SC_RESPAWNTIMER_load_InHigh) begin
            timerCount <= LOAD_VALUE;
        end else if (SC_RESPAWNTIMER_enable_InHigh && (timerCount != '0)) begin
            timerCount <= timerCount - TIMER_WIDTH'(1);
        end
    end

    assign SC_RESPAWNTIMER_zero_OutHigh = (timerCount == '0);

endmodule

// File: rtl/sc_life_controller.sv
// ---------------------------------------------------------------------------
// sc_life_controller
// Game-level sequencer owning the player life counter. Converts start,
// collision and bonus events into the counter's up/down command and
// active-low clear, holds a respawn grace period after each hit, and
// declares game-over when lives reach zero.
//
// State table:
//   IDLE     (0) | waiting for start, movers frozen
//   INIT     (1) | one-cycle counter clear (reload to 3 lives)
//   PLAY     (2) | game running; hits and bonuses accepted
//   HIT      (3) | one-cycle decrement command
//   CHECK    (4) | wait for the counter to settle, then decide
//   RESPAWN  (5) | grace period, events ignored, movers frozen
//   GAMEOVER (6) | no lives left; start begins a new game
//   7            | unused, recovers to IDLE
//
// Ports:
//   SC_LIFECTRL_CLOCK_50          in   system clock, rising edge
//   SC_LIFECTRL_RESET_InLow       in   async active-low reset
//   SC_LIFECTRL_start_InLow       in   debounced start button, active-low
//   SC_LIFECTRL_collision_InHigh  in   one-cycle hit pulse
//   SC_LIFECTRL_bonus_InHigh      in   one-cycle extra-life pulse
//   SC_LIFECTRL_lives_InBUS       in   life counter value
//   SC_LIFECTRL_upcount_OutBUS    out  counter command (10 dec, 01 inc, 00 hold)
//   SC_LIFECTRL_clear_OutLow      out  counter reload, active-low
//   SC_LIFECTRL_freeze_OutHigh    out  movers halted
//   SC_LIFECTRL_respawn_OutHigh   out  one-cycle frog return pulse
//   SC_LIFECTRL_gameover_OutHigh  out  game-over level
//   SC_LIFECTRL_state_OutBUS      out  current state encoding
// ---------------------------------------------------------------------------
module sc_life_controller
    import sc_frogger_pkg::*;
#(
    parameter int LIFECTRL_DATAWIDTH      = 8,
    parameter int LIFECTRL_MAX_LIVES      = 9,
    parameter int LIFECTRL_RESPAWN_CYCLES = 25000000
) (
    input  logic                          SC_LIFECTRL_CLOCK_50,
    input  logic                          SC_LIFECTRL_RESET_InLow,
    input  logic                          SC_LIFECTRL_start_InLow,
    input  logic                          SC_LIFECTRL_collision_InHigh,
    input  logic                          SC_LIFECTRL_bonus_InHigh,
    input  logic [LIFECTRL_DATAWIDTH-1:0] SC_LIFECTRL_lives_InBUS,
    output logic [1:0]                    SC_LIFECTRL_upcount_OutBUS,
    output logic                          SC_LIFECTRL_clear_OutLow,
    output logic                          SC_LIFECTRL_freeze_OutHigh,
    output logic                          SC_LIFECTRL_respawn_OutHigh,
    output logic                          SC_LIFECTRL_gameover_OutHigh,
    output logic [2:0]                    SC_LIFECTRL_state_OutBUS
);

    localparam logic [LIFECTRL_DATAWIDTH-1:0] MAX_LIVES_W = LIFECTRL_DATAWIDTH'(LIFECTRL_MAX_LIVES);

    logic [2:0] stateReg;
    logic [2:0] stateNext;
    logic [1:0] upcountReg;
    logic [1:0] upcountNext;
    logic       clearReg;
    logic       clearNext;
    logic       freezeReg;
    logic       freezeNext;
    logic       respawnReg;
    logic       respawnNext;
    logic       gameoverReg;
    logic       gameoverNext;
    logic       timerLoad;
    logic       timerEnable;
    logic       timerZero;
    logic       livesZero;
    logic       bonusAllowed;

    assign livesZero    = (SC_LIFECTRL_lives_InBUS == '0);
    assign bonusAllowed = (SC_LIFECTRL_lives_InBUS < MAX_LIVES_W);

    sc_respawn_timer #(
        .RESPAWN_CYCLES (LIFECTRL_RESPAWN_CYCLES)
    ) respawnTimer (
        .SC_RESPAWNTIMER_CLOCK_50      (SC_LIFECTRL_CLOCK_50),
        .SC_RESPAWNTIMER_RESET_InLow   (SC_LIFECTRL_RESET_InLow),
        .SC_RESPAWNTIMER_load_InHigh   (timerLoad),
        .SC_RESPAWNTIMER_enable_InHigh (timerEnable),
        .SC_RESPAWNTIMER_zero_OutHigh  (timerZero)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:     if (!SC_LIFECTRL_start_InLow) stateNext = INIT;
            INIT:     stateNext = PLAY;
            PLAY:     if (SC_LIFECTRL_collision_InHigh) stateNext = HIT;
            HIT:      stateNext = CHECK;
            CHECK:    stateNext = livesZero ? GAMEOVER : RESPAWN;
            RESPAWN:  if (timerZero) stateNext = PLAY;
            GAMEOVER: if (!SC_LIFECTRL_start_InLow) stateNext = INIT;
            default:  stateNext = IDLE;
        endcase
    end

    // Loading on the CHECK->RESPAWN edge makes the first RESPAWN cycle see
    // RESPAWN_CYCLES-1, so the grace period lasts exactly RESPAWN_CYCLES.
    assign timerLoad   = (stateReg == CHECK) && !livesZero;
    assign timerEnable = (stateReg == RESPAWN);

    // Outputs are computed one cycle ahead and registered, so each one is
    // valid for the whole cycle of the state it belongs to.
    always_comb begin
        upcountNext = CMD_HOLD;
        if (stateReg == PLAY) begin
            if (SC_LIFECTRL_collision_InHigh) begin
                upcountNext = CMD_DEC;
            end else if (SC_LIFECTRL_bonus_InHigh && bonusAllowed) begin
                upcountNext = CMD_INC;
            end
        end
        clearNext    = (stateNext != INIT);
        freezeNext   = (stateNext != PLAY);
        respawnNext  = timerLoad;
        gameoverNext = (stateNext == GAMEOVER);
    end

    always_ff @(posedge SC_LIFECTRL_CLOCK_50 or negedge SC_LIFECTRL_RESET_InLow) begin
        if (!SC_LIFECTRL_RESET_InLow) begin
            stateReg    <= IDLE;
            upcountReg  <= CMD_HOLD;
            clearReg    <= 1'b1;
            freezeReg   <= 1'b1;
            respawnReg  <= 1'b0;
            gameoverReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            upcountReg  <= upcountNext;
            clearReg    <= clearNext;
            freezeReg   <= freezeNext;
            respawnReg  <= respawnNext;
            gameoverReg <= gameoverNext;
        end
    end

    assign SC_LIFECTRL_upcount_OutBUS   = upcountReg;
    assign SC_LIFECTRL_clear_OutLow     = clearReg;
    assign SC_LIFECTRL_freeze_OutHigh   = freezeReg;
    assign SC_LIFECTRL_respawn_OutHigh  = respawnReg;
    assign SC_LIFECTRL_gameover_OutHigh = gameoverReg;
    assign SC_LIFECTRL_state_OutBUS     = stateReg;

endmodule
